// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b, LSB first) with a start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-2:0] sr;
  logic             borrow;
  logic [CW-1:0]    count;
`ifdef SERIAL_SUB_OVF_EN
  logic             amsb;
  logic             bmsb;
`endif

  logic             abit;
  logic             bbit;
  logic             d;
  logic             borrow_next;
  logic [WIDTH-1:0] res;

  // Single full-subtractor cell; res is the result register with this cycle's bit inserted.
  always_comb begin
    abit        = sa[0];
    bbit        = sb[0];
    d           = abit ^ bbit ^ borrow;
    borrow_next = (~abit & bbit) | (~(abit ^ bbit) & borrow);
    res         = {d, sr};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      sa     <= '0;
      sb     <= '0;
      sr     <= '0;
      borrow <= 1'b0;
      count  <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
      amsb   <= 1'b0;
      bmsb   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sa     <= a;
            sb     <= b;
            borrow <= 1'b0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= RUN;
`ifdef SERIAL_SUB_OVF_EN
            amsb   <= a[WIDTH-1];
            bmsb   <= b[WIDTH-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          sr     <= res[WIDTH-1:1];
          borrow <= borrow_next;
          count  <= count + CW'(1);
          // Last bit: publish the result; start is ignored throughout RUN.
          if (count == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            diff  <= res;
            bout  <= borrow_next;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= (amsb != bmsb) && (d != amsb);
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vector table, handshake corner
// sequences and randomized operands checked against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int nchk;
  int nerr;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain unsigned/signed arithmetic on the operands.
  function automatic logic [W-1:0] m_diff(input int unsigned x, input int unsigned y);
    return W'(x - y);
  endfunction

  function automatic logic m_bout(input int unsigned x, input int unsigned y);
    return x < y;
  endfunction

  function automatic logic m_ovf(input int unsigned x, input int unsigned y);
    int sx, sy, r;
    sx = (x >= 2 ** (W - 1)) ? int'(x) - 2 ** W : int'(x);
    sy = (y >= 2 ** (W - 1)) ? int'(y) - 2 ** W : int'(y);
    r  = sx - sy;
    return (r > 2 ** (W - 1) - 1) || (r < -(2 ** (W - 1)));
  endfunction

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_diff"}, 32'(diff), 32'd0);
    chk({tag, "_bout"}, 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
`endif
  endtask

  // One full operation from IDLE: latency, busy length, single done pulse and results.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [W-1:0] ediff,
                        input logic ebout, input logic eovf, input string tag);
    int busy_cycles;
    int done_at;
    busy_cycles = 0;
    done_at = -1;
    @(negedge clk);
    a = ta;
    b = tb_;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    for (int k = 0; k < 20; k++) begin
      if (busy) busy_cycles++;
      if (done) begin
        done_at = k;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk({tag, "_latency"}, 32'(done_at), 32'd8);
    chk({tag, "_busy_len"}, 32'(busy_cycles), 32'd8);
    chk({tag, "_diff"}, 32'(diff), 32'(ediff));
    chk({tag, "_bout"}, 32'(bout), 32'(ebout));
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(eovf));
`endif
    @(posedge clk);
    #1;
    chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
    chk({tag, "_hold_diff"}, 32'(diff), 32'(ediff));
  endtask

  vec_t tbl[7];

  initial begin
    int ndone;
    int last_done;
    int x, y;
    nchk = 0;
    nerr = 0;
    tbl[0] = '{a: 8'h05, b: 8'h03, diff: 8'h02, bout: 1'b0, ovf: 1'b0};
    tbl[1] = '{a: 8'h03, b: 8'h05, diff: 8'hFE, bout: 1'b1, ovf: 1'b0};
    tbl[2] = '{a: 8'h00, b: 8'h00, diff: 8'h00, bout: 1'b0, ovf: 1'b0};
    tbl[3] = '{a: 8'hFF, b: 8'hFF, diff: 8'h00, bout: 1'b0, ovf: 1'b0};
    tbl[4] = '{a: 8'h80, b: 8'h01, diff: 8'h7F, bout: 1'b0, ovf: 1'b1};
    tbl[5] = '{a: 8'h10, b: 8'h01, diff: 8'h0F, bout: 1'b0, ovf: 1'b0};
    tbl[6] = '{a: 8'h20, b: 8'h08, diff: 8'h18, bout: 1'b0, ovf: 1'b0};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    #1;
    chk_outputs_zero("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) run_op(tbl[i].a, tbl[i].b, tbl[i].diff, tbl[i].bout, tbl[i].ovf, $sformatf("vec%0d", i));

    // Reset while idle with non-zero results held: clears asynchronously.
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "pre_rst");
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_outputs_zero("idle_rst");
    @(negedge clk);
    rst = 1'b0;

    // Start re-pulsed during RUN is ignored.
    @(negedge clk);
    a = 8'h05;
    b = 8'h03;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = 8'h09;
    b = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        chk("repulse_diff", 32'(diff), 32'h02);
      end
    end
    chk("repulse_ndone", 32'(ndone), 32'd1);
    chk("repulse_idle", 32'(busy), 32'd0);

    // Start held high: one operation every WIDTH+1 cycles.
    @(negedge clk);
    a = 8'h07;
    b = 8'h02;
    start = 1'b1;
    ndone = 0;
    last_done = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        chk("held_diff", 32'(diff), 32'h05);
        if (last_done >= 0) chk("held_period", 32'(k - last_done), 32'd9);
        last_done = k;
      end
    end
    chk("held_ndone", 32'(ndone), 32'd4);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(posedge clk);

    // Reset during the 4th RUN cycle aborts without a done pulse.
    @(negedge clk);
    a = 8'h33;
    b = 8'h11;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_outputs_zero("run_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    chk("run_rst_quiet", 32'(ndone), 32'd0);
    run_op(8'h20, 8'h08, 8'h18, 1'b0, 1'b0, "after_rst");

    // Randomized operands against the arithmetic model.
    for (int n = 0; n < 150; n++) begin
      x = int'($urandom_range(0, 255));
      y = int'($urandom_range(0, 255));
      if (n < 4) begin
        x = (n[0]) ? 255 : 0;
        y = (n[1]) ? 255 : 0;
      end
      run_op(W'(x), W'(y), m_diff(x, y), m_bout(x, y), m_ovf(x, y), $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
